argmax_frame_sequencer: RTL

//   Frames a stream of signed samples into argmax jobs, one job per frame.

---
 rtl/argmax_frame_sequencer.sv | 101 ++++++++++
 1 files changed

// File: rtl/argmax_frame_sequencer.sv
// Frames a signed sample stream into argmax jobs and returns {argmax, max} per frame.
// Optional abort port and frame cancellation are enabled by defining ARGMAX_ABORT_EN.
`timescale 1ns/1ps

module argmax_frame_sequencer #(
  parameter int WIDTH        = 4,
  parameter int ARGMAX_WIDTH = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [ARGMAX_WIDTH-1:0] len_m1,
  output logic                    busy,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WIDTH-1:0]        in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ARGMAX_WIDTH-1:0] out_argmax,
  output logic [WIDTH-1:0]        out_max
`ifdef ARGMAX_ABORT_EN
  ,
  input  logic                    abort
`endif
);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t                   state, state_nxt;
  logic [ARGMAX_WIDTH-1:0]  len_q;
  logic [ARGMAX_WIDTH-1:0]  idx;
  logic [ARGMAX_WIDTH-1:0]  run_arg, arg_nxt;
  logic signed [WIDTH-1:0]  run_max, max_nxt;
  logic                     kill;
  logic                     take;
  logic                     last;
  logic                     new_best;

`ifdef ARGMAX_ABORT_EN
  assign kill = abort && (state != IDLE);
`else
  assign kill = 1'b0;
`endif

  // A cancelled cycle accepts nothing, even though in_ready is still high.
  assign take = (state == ACCUM) && in_valid && !kill;
  assign last = take && (idx == len_q);

  // First sample of a frame always wins; afterwards only a strictly larger one does.
  assign new_best = (idx == '0) || ($signed(in_data) > run_max);
  assign max_nxt  = new_best ? $signed(in_data) : run_max;
  assign arg_nxt  = new_best ? idx : run_arg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    busy      = (state != IDLE);
    in_ready  = (state == ACCUM);
    out_valid = (state == DONE);
    case (state)
      IDLE:    if (start) state_nxt = ACCUM;
      ACCUM:   if (last) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (kill) state_nxt = IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      len_q      <= '0;
      idx        <= '0;
      run_arg    <= '0;
      run_max    <= '0;
      out_argmax <= '0;
      out_max    <= '0;
    end else begin
      if (state == IDLE && start) begin
        len_q <= len_m1;
        idx   <= '0;
      end
      // idx wraps only after the final compare, so a full-range frame is safe.
      if (take) begin
        idx     <= idx + 1'b1;
        run_max <= max_nxt;
        run_arg <= arg_nxt;
        if (last) begin
          out_max    <= max_nxt;
          out_argmax <= arg_nxt;
        end
      end
    end
  end

endmodule
